// File: rtl/target_placer.sv
// target_placer
//   Owns the snake's target position. On an eat event it requests a random
//   address from the target generator, folds it into the playfield and,
//   when body-collision checking is compiled in, asks the body tracker
//   whether the cell is occupied. It then commits the address as the new
//   target. It also keeps a saturating score of eaten targets.
//
//   Build option: define TARGET_COLLISION_CHECK_EN to compile in the QUERY
//   state, the retry counter and the forced-placement strobe. Without it,
//   FOLD goes straight to COMMIT and the query/forced outputs are tied to 0.
//
//   Ports
//     CLK, RESET     clock, synchronous active-high reset
//     EAT            one-cycle pulse: head reached the target
//     RND_ADDR       random address {x[7:0], y[6:0]} from the generator
//     TRG_REQ        generator request; RND_ADDR is captured in this cycle
//     QRY_VALID      body-occupancy query strobe, QRY_ADDR = address queried
//     QRY_DONE       query response strobe, QRY_HIT = cell occupied
//     TARGET_ADDR    committed target {x, y}, TARGET_VALID = address is current
//     SCORE          saturating count of targets eaten
//     PLACE_FORCED   one-cycle pulse: committed despite a hit on the last try
module target_placer #(
  parameter int X_MAX     = 160,
  parameter int Y_MAX     = 120,
  parameter int INIT_X    = 80,
  parameter int INIT_Y    = 60,
  parameter int MAX_TRIES = 8,
  parameter int SCORE_W   = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               EAT,
  input  logic [14:0]        RND_ADDR,
  output logic               TRG_REQ,
  output logic               QRY_VALID,
  output logic [14:0]        QRY_ADDR,
  input  logic               QRY_DONE,
  input  logic               QRY_HIT,
  output logic [14:0]        TARGET_ADDR,
  output logic               TARGET_VALID,
  output logic [SCORE_W-1:0] SCORE,
  output logic               PLACE_FORCED
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    FOLD   = 3'd2,
    QUERY  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam logic [7:0]         X_LIM     = 8'(X_MAX);
  localparam logic [6:0]         Y_LIM     = 7'(Y_MAX);
  localparam logic [14:0]        INIT_ADDR = {8'(INIT_X), 7'(INIT_Y)};
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

`ifdef TARGET_COLLISION_CHECK_EN
  localparam int             TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  logic [TRY_W-1:0] tries_r;
  logic             forced_r;
`else
  localparam int unused_tries_p = MAX_TRIES;
  logic unused_s;
  assign unused_s = QRY_DONE ^ QRY_HIT;
`endif

  state_t      state_r;
  logic [14:0] candidate_r;

  // Wrap a raw generator address into the playfield. Both coordinates are
  // below twice their limit, so one subtraction always lands in range.
  function automatic logic [14:0] fold_addr(input logic [14:0] raw);
    logic [7:0] fx;
    logic [6:0] fy;
    fx = raw[14:7];
    fy = raw[6:0];
    if (fx >= X_LIM) begin
      fx = fx - X_LIM;
    end else begin
      fx = fx;
    end
    if (fy >= Y_LIM) begin
      fy = fy - Y_LIM;
    end else begin
      fy = fy;
    end
    return {fx, fy};
  endfunction

  // Placement state machine, target register and score counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= IDLE;
      TARGET_ADDR  <= INIT_ADDR;
      TARGET_VALID <= 1'b1;
      SCORE        <= '0;
      candidate_r  <= 15'd0;
`ifdef TARGET_COLLISION_CHECK_EN
      tries_r      <= '0;
      forced_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (EAT) begin
            state_r      <= REQ;
            TARGET_VALID <= 1'b0;
`ifdef TARGET_COLLISION_CHECK_EN
            tries_r      <= '0;
            forced_r     <= 1'b0;
`endif
            if (SCORE != SCORE_MAX) begin
              SCORE <= SCORE + SCORE_W'(1);
            end
          end
        end
        REQ: begin
          candidate_r <= RND_ADDR;
          state_r     <= FOLD;
        end
        FOLD: begin
          candidate_r <= fold_addr(candidate_r);
`ifdef TARGET_COLLISION_CHECK_EN
          state_r     <= QUERY;
`else
          state_r     <= COMMIT;
`endif
        end
`ifdef TARGET_COLLISION_CHECK_EN
        QUERY: begin
          if (QRY_DONE) begin
            if (!QRY_HIT) begin
              state_r <= COMMIT;
            end else if (tries_r == LAST_TRY) begin
              // Out of attempts: keep the last candidate and flag it.
              forced_r <= 1'b1;
              state_r  <= COMMIT;
            end else begin
              tries_r <= tries_r + TRY_W'(1);
              state_r <= REQ;
            end
          end
        end
`endif
        COMMIT: begin
          TARGET_ADDR  <= candidate_r;
          TARGET_VALID <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Strobes decoded from the state register.
  always_comb begin
    TRG_REQ = (state_r == REQ);
`ifdef TARGET_COLLISION_CHECK_EN
    QRY_VALID    = (state_r == QUERY);
    QRY_ADDR     = candidate_r;
    PLACE_FORCED = (state_r == COMMIT) && forced_r;
`else
    QRY_VALID    = 1'b0;
    QRY_ADDR     = 15'd0;
    PLACE_FORCED = 1'b0;
`endif
  end

endmodule

// File: tb/tb_target_placer.sv
// Randomized scoreboard bench for target_placer. Each placement pushes its
// expected outcome (target, score, request count, forced strobe, blanking
// length) computed from the placement rules; a monitor pops and compares
// whenever TARGET_VALID returns high.
module tb_target_placer;

  localparam int X_MAX     = 160;
  localparam int Y_MAX     = 120;
  localparam int MAX_TRIES = 8;
  localparam logic [14:0] INIT_ADDR = 15'h283C;

  typedef struct {
    logic [14:0] addr;
    int          score;
    int          reqs;
    int          forced;
    int          base;
    int          w_base;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        eat = 1'b0;
  logic [14:0] rnd_addr;
  logic        trg_req;
  logic        qry_valid;
  logic [14:0] qry_addr;
  logic        qry_done = 1'b0;
  logic        qry_hit = 1'b0;
  logic [14:0] target_addr;
  logic        target_valid;
  logic [7:0]  score;
  logic        place_forced;

  int n_vec = 0;
  int n_err = 0;

  logic [14:0] gen_vals [MAX_TRIES];
  int   req_seen = 0;
  int   gen_base = 0;
  int   q_seen = 0;
  int   q_base = 0;
  int   hit_target = 0;
  int   wait_total = 0;
  int   wait_cnt = 0;
  bit   hold_done = 1'b0;
  bit   mon_en = 1'b1;
  int   score_m = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  target_placer dut (
    .CLK(clk), .RESET(reset), .EAT(eat), .RND_ADDR(rnd_addr),
    .TRG_REQ(trg_req), .QRY_VALID(qry_valid), .QRY_ADDR(qry_addr),
    .QRY_DONE(qry_done), .QRY_HIT(qry_hit), .TARGET_ADDR(target_addr),
    .TARGET_VALID(target_valid), .SCORE(score), .PLACE_FORCED(place_forced)
  );

  // Generator model: returns the next queued value only while requested.
  assign rnd_addr = trg_req ? gen_vals[(req_seen - gen_base) % MAX_TRIES] : 15'd0;

  always @(posedge clk) begin
    if (trg_req) req_seen <= req_seen + 1;
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  // Reference fold: coordinates reduced modulo the playfield size.
  function automatic logic [14:0] model_fold(input logic [14:0] r);
    int x;
    int y;
    x = int'(r[14:7]) % X_MAX;
    y = int'(r[6:0]) % Y_MAX;
    return {x[7:0], y[6:0]};
  endfunction

  // Body tracker model: answers after a random wait, hit for the first
  // hit_target queries of the current placement.
  always @(negedge clk) begin
    qry_done = 1'b0;
    qry_hit  = 1'b0;
    if (qry_valid) begin
      if (hold_done) begin
        wait_total++;
      end else if (wait_cnt == 0) begin
        check("qry_addr", int'(qry_addr),
              int'(model_fold(gen_vals[(q_seen - q_base) % MAX_TRIES])));
        qry_done = 1'b1;
        qry_hit  = ((q_seen - q_base) < hit_target);
        q_seen++;
        wait_cnt = $urandom_range(0, 2);
      end else begin
        wait_cnt--;
        wait_total++;
      end
    end
  end

  // Monitor: on each return of TARGET_VALID pop and compare the scoreboard.
  int   forced_cnt = 0;
  int   low_cnt = 0;
  int   qv_cnt = 0;
  logic prev_valid = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (place_forced) forced_cnt++;
    if (!target_valid) low_cnt++;
    if (qry_valid) qv_cnt++;
    if (target_valid && !prev_valid && mon_en) begin
      if (sb.size() == 0) begin
        check("unexpected_commit", 1, 0);
      end else begin
        e = sb.pop_front();
        check("target_addr", int'(target_addr), int'(e.addr));
        check("score", int'(score), e.score);
        check("trg_req_count", req_seen - e.base, e.reqs);
        check("place_forced_count", forced_cnt, e.forced);
`ifdef TARGET_COLLISION_CHECK_EN
        check("valid_low_cycles", low_cnt, 3 * e.reqs + 1 + (wait_total - e.w_base));
        check("query_cycles", qv_cnt, e.reqs + (wait_total - e.w_base));
`else
        check("valid_low_cycles", low_cnt, 3);
        check("query_cycles", qv_cnt, 0);
`endif
      end
    end
    if (target_valid) begin
      forced_cnt = 0;
      low_cnt    = 0;
      qv_cnt     = 0;
    end
    prev_valid = target_valid;
  end

  task automatic wait_valid();
    for (int c = 0; c < 400 && !target_valid; c++) @(negedge clk);
    if (!target_valid) check("placement_timeout", 0, 1);
  endtask

  // One placement: hits = number of leading body hits the tracker reports.
  task automatic run_placement(input int hits, input bit extra, input bit fixed,
                               input logic [14:0] v0);
    exp_t e;
    int   ntry;
    for (int k = 0; k < MAX_TRIES; k++) begin
      gen_vals[k] = fixed ? v0 + 15'(k * 129) : 15'($urandom_range(0, 32767));
    end
`ifdef TARGET_COLLISION_CHECK_EN
    ntry     = (hits < MAX_TRIES) ? hits + 1 : MAX_TRIES;
    e.forced = (hits >= MAX_TRIES) ? 1 : 0;
`else
    ntry     = 1;
    e.forced = 0;
`endif
    e.addr     = model_fold(gen_vals[ntry - 1]);
    e.reqs     = ntry;
    e.base     = req_seen;
    e.w_base   = wait_total;
    hit_target = hits;
    q_base     = q_seen;
    gen_base   = req_seen;
    if (score_m < 255) score_m++;
    e.score = score_m;
    sb.push_back(e);
    eat = 1'b1;
    @(negedge clk);
    eat = 1'b0;
    if (extra) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      if (!target_valid) begin
        eat = 1'b1;
        @(negedge clk);
        eat = 1'b0;
      end
    end
    wait_valid();
    @(negedge clk);
  endtask

  initial begin
    int hits;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_target_addr", int'(target_addr), int'(INIT_ADDR));
    check("rst_target_valid", int'(target_valid), 1);
    check("rst_score", int'(score), 0);
    check("rst_strobes", int'({trg_req, qry_valid, place_forced}), 0);
    @(negedge clk);

    // {200,125} folds to {40,5}.
    run_placement(0, 1'b0, 1'b1, {8'd200, 7'd125});
`ifdef TARGET_COLLISION_CHECK_EN
    gen_vals[0] = 15'd0;
    run_placement(2, 1'b0, 1'b1, {8'd10, 7'd10});
    run_placement(MAX_TRIES, 1'b0, 1'b0, 15'd0);
`endif
    // Random placements; enough eats to push the score past saturation.
    for (int i = 0; i < 262; i++) begin
      hits = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX_TRIES) : 0;
      run_placement(hits, ($urandom_range(0, 3) == 0), 1'b0, 15'd0);
    end
    check("score_saturated", int'(score), 255);

    // Reset in the middle of a placement.
    mon_en    = 1'b0;
    hold_done = 1'b1;
    eat = 1'b1;
    @(negedge clk);
    eat = 1'b0;
`ifdef TARGET_COLLISION_CHECK_EN
    for (int c = 0; c < 10 && !qry_valid; c++) @(negedge clk);
    check("reached_query", int'(qry_valid), 1);
`else
    @(negedge clk);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_target_addr", int'(target_addr), int'(INIT_ADDR));
    check("abort_target_valid", int'(target_valid), 1);
    check("abort_qry_valid", int'(qry_valid), 0);
    check("abort_score", int'(score), 0);
    check("abort_trg_req", int'(trg_req), 0);
    hold_done = 1'b0;
    score_m   = 0;
    @(negedge clk);
    mon_en = 1'b1;

    // Normal operation resumes from the reset state.
    run_placement(0, 1'b1, 1'b0, 15'd0);
    run_placement(1, 1'b0, 1'b0, 15'd0);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
